// File: rtl/button_events_pkg.sv
// Shared types and constants for the button_events block.
// The state encoding is fixed here so that debug and observation logic can decode it.
package button_events_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEATING = 2'd2
  } state_e;

  // Default timing for a 27 MHz clk: 0.5 s before the first repeat, then one repeat every 0.1 s.
  localparam int HOLD_DELAY_0P5S = 13500000;
  localparam int REPEAT_0P1S     = 2700000;
  localparam int CNT_WIDTH_DFLT  = 24;

  // Returns 1 when a counter of width w can hold every value below max(a, b).
  function automatic bit cnt_width_ok(int w, int a, int b);
    longint unsigned lim;
    lim = longint'(1) << w;
    return (lim > longint'(a)) && (lim > longint'(b));
  endfunction

endpackage

// File: rtl/button_events_if.sv
// Button level in, UI events out. release and repeat are reserved words in SystemVerilog,
// so those two pulses carry a _pulse suffix.
interface button_events_if;
  logic clean;
  logic press;
  logic release_pulse;
  logic repeat_pulse;
  logic step;
  logic held;

  modport master (
    output clean,
    input  press, release_pulse, repeat_pulse, step, held
  );

  modport slave (
    input  clean,
    output press, release_pulse, repeat_pulse, step, held
  );
endinterface

// File: rtl/button_events.sv
// Turns one debounced button level into press, release and auto-repeat pulses.
// All outputs are registered. Reset re-arms edge detection from the current level.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// IDLE      | button up, or held since reset; waiting for a fresh rising edge
// WAIT_HOLD | pressed; counting HOLD_DELAY cycles towards the first repeat
// REPEATING | held long enough; one repeat every REPEAT_PERIOD cycles
module button_events
  import button_events_pkg::*;
#(
  parameter int HOLD_DELAY    = HOLD_DELAY_0P5S,
  parameter int REPEAT_PERIOD = REPEAT_0P1S,
  parameter int CNT_WIDTH     = CNT_WIDTH_DFLT
) (
  input  logic              clock,
  input  logic              reset,
  button_events_if.slave    bus
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 prev_q, prev_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 repeat_q, repeat_d;
  logic                 step_q, step_d;
  logic                 held_q, held_d;
  logic                 rise;

  assign rise = bus.clean & ~prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = bus.clean;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    held_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_HOLD;
        end
      end

      WAIT_HOLD: begin
        if (!bus.clean) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          repeat_d = 1'b1;
          held_d   = 1'b1;
          cnt_d    = '0;
          state_d  = REPEATING;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      REPEATING: begin
        // Checking the level first lets a release swallow a repeat that falls due in the same cycle.
        if (!bus.clean) begin
          release_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          held_d = 1'b1;
          if (cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    step_d = press_d | repeat_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prev_q    <= bus.clean;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      step_q    <= step_d;
      held_q    <= held_d;
    end
  end

  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.step          = step_q;
  assign bus.held          = held_q;

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with HOLD_DELAY=8, REPEAT_PERIOD=3, CNT_WIDTH=4.
// Each vector bit e is the input applied at, or the output expected after, edge e.
module tb_button_events;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  button_events_if bus();

  button_events #(
    .HOLD_DELAY    (8),
    .REPEAT_PERIOD (3),
    .CNT_WIDTH     (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    bus.clean = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Output order in all comparisons: press release repeat step held
  task automatic test_reset();
    logic [23:0] cl, rs, ep, er, et, eh;
    logic [4:0]  got, exp;
    cl = 24'h0000BF;
    rs = 24'h000003;
    ep = 24'h000080;
    er = 24'h000100;
    et = 24'h000000;
    eh = 24'h000000;
    for (int e = 0; e < 10; e++) begin
      bus.clean = cl[e];
      reset     = rs[e];
      tick();
      got = {bus.press, bus.release_pulse, bus.repeat_pulse, bus.step, bus.held};
      exp = {ep[e], er[e], et[e], ep[e] | et[e], eh[e]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_powerup edge %0d: got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_short_tap();
    logic [23:0] cl, ep, er, et, eh;
    logic [4:0]  got, exp;
    apply_reset();
    cl = 24'h00000F;
    ep = 24'h000001;
    er = 24'h000010;
    et = 24'h000000;
    eh = 24'h000000;
    for (int e = 0; e < 10; e++) begin
      bus.clean = cl[e];
      tick();
      got = {bus.press, bus.release_pulse, bus.repeat_pulse, bus.step, bus.held};
      exp = {ep[e], er[e], et[e], ep[e] | et[e], eh[e]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL short_tap edge %0d: got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [23:0] cl, ep, er, et, eh;
    logic [4:0]  got, exp;
    apply_reset();
    cl = 24'h03FFFF;
    ep = 24'h000001;
    er = 24'h040000;
    et = 24'h024900;
    eh = 24'h03FF00;
    for (int e = 0; e < 23; e++) begin
      bus.clean = cl[e];
      tick();
      got = {bus.press, bus.release_pulse, bus.repeat_pulse, bus.step, bus.held};
      exp = {ep[e], er[e], et[e], ep[e] | et[e], eh[e]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL long_hold edge %0d: got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_release_on_repeat();
    logic [23:0] cl, ep, er, et, eh;
    logic [4:0]  got, exp;
    apply_reset();
    cl = 24'h0FFFFF;
    ep = 24'h000001;
    er = 24'h100000;
    et = 24'h024900;
    eh = 24'h0FFF00;
    for (int e = 0; e < 24; e++) begin
      bus.clean = cl[e];
      tick();
      got = {bus.press, bus.release_pulse, bus.repeat_pulse, bus.step, bus.held};
      exp = {ep[e], er[e], et[e], ep[e] | et[e], eh[e]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL release_on_repeat edge %0d: got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_release_before_repeat();
    logic [23:0] cl, ep, er, et, eh;
    logic [4:0]  got, exp;
    apply_reset();
    cl = 24'h00007F;
    ep = 24'h000001;
    er = 24'h000080;
    et = 24'h000000;
    eh = 24'h000000;
    for (int e = 0; e < 13; e++) begin
      bus.clean = cl[e];
      tick();
      got = {bus.press, bus.release_pulse, bus.repeat_pulse, bus.step, bus.held};
      exp = {ep[e], er[e], et[e], ep[e] | et[e], eh[e]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL release_before_repeat edge %0d: got %b expected %b", e, got, exp);
      end
    end
  endtask

  task automatic test_reset_while_held();
    logic [23:0] cl, rs, ep, er, et, eh;
    logic [4:0]  got, exp;
    apply_reset();
    cl = 24'hFC7FFF;
    rs = 24'h000400;
    ep = 24'h040001;
    er = 24'h000000;
    et = 24'h000100;
    eh = 24'h000300;
    for (int e = 0; e < 24; e++) begin
      bus.clean = cl[e];
      reset     = rs[e];
      tick();
      got = {bus.press, bus.release_pulse, bus.repeat_pulse, bus.step, bus.held};
      exp = {ep[e], er[e], et[e], ep[e] | et[e], eh[e]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_while_held edge %0d: got %b expected %b", e, got, exp);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.clean = 1'b1;
    test_reset();
    test_short_tap();
    test_long_hold();
    test_release_on_repeat();
    test_release_before_repeat();
    test_reset_while_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
